// File: rtl/leve1_id.sv
// rtl/leve1_id.sv - LEVE1 RV64I instruction decode stage with 2-entry skid buffer
//
// Decodes (PC, instruction) pairs from fetch into register indices, enables,
// instruction class and sign-extended immediate. The decoded entry is held in
// an output register (slot A) backed by a skid register (slot B), so IREADY
// depends only on registered state and never on OREADY.
//
// Ports:
//   CLK, RSTn          clock, asynchronous active-low reset
//   FLUSH              redirect: drop every buffered entry and any same-cycle input
//   IVALID/IREADY      input handshake from fetch
//   IPC, IINSTR        instruction PC and 32-bit instruction word
//   OVALID/OREADY      output handshake to execute
//   OPC, OINSTR        PC and raw instruction of the presented entry
//   OCLASS             instruction class (0 = ILLEGAL ... 13 = SYSTEM)
//   OFUNCT3, OALT      instr[14:12] and instr[30]
//   ORS1, ORS2, ORD    register indices
//   ORS1_EN, ORS2_EN   source register reads required
//   ORD_WE             destination write (never for x0)
//   OIMM               sign-extended immediate
module leve1_id #(
    parameter int XLEN = 64
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            FLUSH,
    input  logic            IVALID,
    output logic            IREADY,
    input  logic [XLEN-1:0] IPC,
    input  logic [31:0]     IINSTR,
    output logic            OVALID,
    input  logic            OREADY,
    output logic [XLEN-1:0] OPC,
    output logic [31:0]     OINSTR,
    output logic [3:0]      OCLASS,
    output logic [2:0]      OFUNCT3,
    output logic            OALT,
    output logic [4:0]      ORS1,
    output logic [4:0]      ORS2,
    output logic [4:0]      ORD,
    output logic            ORS1_EN,
    output logic            ORS2_EN,
    output logic            ORD_WE,
    output logic [XLEN-1:0] OIMM
);

    localparam logic [3:0] CLS_ILLEGAL = 4'd0;
    localparam logic [3:0] CLS_LUI     = 4'd1;
    localparam logic [3:0] CLS_AUIPC   = 4'd2;
    localparam logic [3:0] CLS_JAL     = 4'd3;
    localparam logic [3:0] CLS_JALR    = 4'd4;
    localparam logic [3:0] CLS_BRANCH  = 4'd5;
    localparam logic [3:0] CLS_LOAD    = 4'd6;
    localparam logic [3:0] CLS_STORE   = 4'd7;
    localparam logic [3:0] CLS_OPIMM   = 4'd8;
    localparam logic [3:0] CLS_OP      = 4'd9;
    localparam logic [3:0] CLS_OPIMM32 = 4'd10;
    localparam logic [3:0] CLS_OP32    = 4'd11;
    localparam logic [3:0] CLS_MISCMEM = 4'd12;
    localparam logic [3:0] CLS_SYSTEM  = 4'd13;

    // instr[6:2] major opcodes
    localparam logic [4:0] OPC_LOAD    = 5'b00000;
    localparam logic [4:0] OPC_MISCMEM = 5'b00011;
    localparam logic [4:0] OPC_OPIMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC   = 5'b00101;
    localparam logic [4:0] OPC_OPIMM32 = 5'b00110;
    localparam logic [4:0] OPC_STORE   = 5'b01000;
    localparam logic [4:0] OPC_OP      = 5'b01100;
    localparam logic [4:0] OPC_LUI     = 5'b01101;
    localparam logic [4:0] OPC_OP32    = 5'b01110;
    localparam logic [4:0] OPC_BRANCH  = 5'b11000;
    localparam logic [4:0] OPC_JALR    = 5'b11001;
    localparam logic [4:0] OPC_JAL     = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM  = 5'b11100;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_sel_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [3:0]      cls;
        logic [2:0]      funct3;
        logic            alt;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            rs1_en;
        logic            rs2_en;
        logic            rd_we;
        logic [XLEN-1:0] imm;
    } entry_t;

    // ------------------------------------------------------------------
    // Combinational decode of IINSTR
    // ------------------------------------------------------------------
    logic [4:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd_idx;
    logic            op_funct7_ok;
    logic [3:0]      dec_class;
    imm_sel_t        imm_sel;
    logic            rs1_use;
    logic            rs2_use;
    logic            rd_use;
    logic [XLEN-1:0] dec_imm;
    entry_t          dec_entry;

    assign opcode = IINSTR[6:2];
    assign funct3 = IINSTR[14:12];
    assign funct7 = IINSTR[31:25];
    assign rd_idx = IINSTR[11:7];

    // OP/OP32: base funct7, or the alternate encoding only for ADD/SUB and SRL/SRA
    assign op_funct7_ok = (funct7 == 7'b0000000) ||
                          ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));

    always_comb begin
        dec_class = CLS_ILLEGAL;
        imm_sel   = IMM_NONE;
        rs1_use   = 1'b0;
        rs2_use   = 1'b0;
        rd_use    = 1'b0;
        if (IINSTR[1:0] == 2'b11) begin
            case (opcode)
                OPC_LUI: begin
                    dec_class = CLS_LUI;
                    imm_sel   = IMM_U;
                    rd_use    = 1'b1;
                end
                OPC_AUIPC: begin
                    dec_class = CLS_AUIPC;
                    imm_sel   = IMM_U;
                    rd_use    = 1'b1;
                end
                OPC_JAL: begin
                    dec_class = CLS_JAL;
                    imm_sel   = IMM_J;
                    rd_use    = 1'b1;
                end
                OPC_JALR: begin
                    if (funct3 == 3'b000) begin
                        dec_class = CLS_JALR;
                        imm_sel   = IMM_I;
                        rs1_use   = 1'b1;
                        rd_use    = 1'b1;
                    end
                end
                OPC_BRANCH: begin
                    if ((funct3 != 3'b010) && (funct3 != 3'b011)) begin
                        dec_class = CLS_BRANCH;
                        imm_sel   = IMM_B;
                        rs1_use   = 1'b1;
                        rs2_use   = 1'b1;
                    end
                end
                OPC_LOAD: begin
                    if (funct3 != 3'b111) begin
                        dec_class = CLS_LOAD;
                        imm_sel   = IMM_I;
                        rs1_use   = 1'b1;
                        rd_use    = 1'b1;
                    end
                end
                OPC_STORE: begin
                    if (!funct3[2]) begin
                        dec_class = CLS_STORE;
                        imm_sel   = IMM_S;
                        rs1_use   = 1'b1;
                        rs2_use   = 1'b1;
                    end
                end
                OPC_OPIMM: begin
                    dec_class = CLS_OPIMM;
                    imm_sel   = IMM_I;
                    rs1_use   = 1'b1;
                    rd_use    = 1'b1;
                end
                OPC_OP: begin
                    if (op_funct7_ok) begin
                        dec_class = CLS_OP;
                        rs1_use   = 1'b1;
                        rs2_use   = 1'b1;
                        rd_use    = 1'b1;
                    end
                end
                OPC_OPIMM32: begin
                    if ((funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b101)) begin
                        dec_class = CLS_OPIMM32;
                        imm_sel   = IMM_I;
                        rs1_use   = 1'b1;
                        rd_use    = 1'b1;
                    end
                end
                OPC_OP32: begin
                    if (op_funct7_ok) begin
                        dec_class = CLS_OP32;
                        rs1_use   = 1'b1;
                        rs2_use   = 1'b1;
                        rd_use    = 1'b1;
                    end
                end
                OPC_MISCMEM: begin
                    dec_class = CLS_MISCMEM;
                end
                OPC_SYSTEM: begin
                    // ECALL/EBREAK/xRET (funct3 0) write nothing; CSR ops write rd
                    dec_class = CLS_SYSTEM;
                    imm_sel   = IMM_I;
                    rd_use    = (funct3 != 3'b000);
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        dec_imm = '0;
        case (imm_sel)
            IMM_I: dec_imm = {{(XLEN-12){IINSTR[31]}}, IINSTR[31:20]};
            IMM_S: dec_imm = {{(XLEN-12){IINSTR[31]}}, IINSTR[31:25], IINSTR[11:7]};
            IMM_B: dec_imm = {{(XLEN-13){IINSTR[31]}}, IINSTR[31], IINSTR[7],
                              IINSTR[30:25], IINSTR[11:8], 1'b0};
            IMM_U: dec_imm = {{(XLEN-32){IINSTR[31]}}, IINSTR[31:12], 12'h000};
            IMM_J: dec_imm = {{(XLEN-21){IINSTR[31]}}, IINSTR[31], IINSTR[19:12],
                              IINSTR[20], IINSTR[30:21], 1'b0};
            default: dec_imm = '0;
        endcase
    end

    always_comb begin
        dec_entry        = '0;
        dec_entry.pc     = IPC;
        dec_entry.instr  = IINSTR;
        dec_entry.cls    = dec_class;
        dec_entry.funct3 = funct3;
        dec_entry.alt    = IINSTR[30];
        dec_entry.rs1    = IINSTR[19:15];
        dec_entry.rs2    = IINSTR[24:20];
        dec_entry.rd     = rd_idx;
        dec_entry.rs1_en = rs1_use;
        dec_entry.rs2_en = rs2_use;
        dec_entry.rd_we  = rd_use && (rd_idx != 5'd0);
        dec_entry.imm    = dec_imm;
    end

    // ------------------------------------------------------------------
    // Two-slot buffer: A drives the outputs, B absorbs one entry of skid
    // ------------------------------------------------------------------
    entry_t a_data;
    entry_t b_data;
    logic   a_valid;
    logic   b_valid;
    logic   in_xfer;
    logic   a_free;

    assign IREADY  = !b_valid;
    assign in_xfer = IVALID && !b_valid;
    assign a_free  = !a_valid || OREADY;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            a_valid <= 1'b0;
            b_valid <= 1'b0;
            a_data  <= '0;
            b_data  <= '0;
        end else if (FLUSH) begin
            a_valid <= 1'b0;
            b_valid <= 1'b0;
        end else if (a_free) begin
            // B only fills while A holds, so B valid implies A valid here;
            // IREADY is low whenever B is valid, so no input competes with the move.
            if (b_valid) begin
                a_data  <= b_data;
                a_valid <= 1'b1;
                b_valid <= 1'b0;
            end else if (in_xfer) begin
                a_data  <= dec_entry;
                a_valid <= 1'b1;
            end else begin
                a_valid <= 1'b0;
            end
        end else if (in_xfer) begin
            b_data  <= dec_entry;
            b_valid <= 1'b1;
        end
    end

    assign OVALID  = a_valid;
    assign OPC     = a_data.pc;
    assign OINSTR  = a_data.instr;
    assign OCLASS  = a_data.cls;
    assign OFUNCT3 = a_data.funct3;
    assign OALT    = a_data.alt;
    assign ORS1    = a_data.rs1;
    assign ORS2    = a_data.rs2;
    assign ORD     = a_data.rd;
    assign ORS1_EN = a_data.rs1_en;
    assign ORS2_EN = a_data.rs2_en;
    assign ORD_WE  = a_data.rd_we;
    assign OIMM    = a_data.imm;

endmodule
